multiseg_display_n: RTL and testbench



---
 rtl/multiseg_display_n_if.sv | 41 ++++
 rtl/multiseg_display_n.sv | 164 ++++++++++++++++
 tb/tb_multiseg_display_n.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/multiseg_display_n_if.sv
// Bus between the value producers and the multiplexed 7-segment driver.
// The master side supplies digit data and display controls. The slave side
// (the driver) returns the registered pin-level outputs.
interface multiseg_display_n_if #(
  parameter int NUM_DIGITS  = 8,
  parameter int BRIGHT_BITS = 4
);
  // Digit data and controls; digit 0 is the rightmost nibble.
  logic [4*NUM_DIGITS-1:0] bcd;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    blank_lz;
  logic [BRIGHT_BITS-1:0]  brightness;

  // Board-facing outputs. All of these are active-low except frame_tick.
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_tick;

  modport master (
    output bcd,
    output dp_in,
    output blank_lz,
    output brightness,
    input  seg,
    input  dp,
    input  an,
    input  frame_tick
  );

  modport slave (
    input  bcd,
    input  dp_in,
    input  blank_lz,
    input  brightness,
    output seg,
    output dp,
    output an,
    output frame_tick
  );
endinterface

// File: rtl/multiseg_display_n.sv
// Time-multiplexed 7-segment driver for NUM_DIGITS common-anode digits.
// Features: per-digit decimal points, leading-zero blanking and PWM
// brightness. Input values are snapshotted once per frame, so a frame is
// never torn by a mid-frame update.
// Optional build macro HEX_DECODE_EN: nibbles 10..15 show A,b,C,d,E,F.
// Without the macro those nibbles leave the segments dark. The anode and
// the decimal point are still driven for them.
// REFRESH_DIV must be a multiple of 2**BRIGHT_BITS. NUM_DIGITS must be 2..16.
module multiseg_display_n #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 50000,
  parameter int BRIGHT_BITS = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  multiseg_display_n_if.slave   bus
);

  localparam int PRE_W  = $clog2(REFRESH_DIV);
  localparam int DSEL_W = $clog2(NUM_DIGITS);

  // Scan position.
  logic [PRE_W-1:0]          prescaler_q, prescaler_d;
  logic [DSEL_W-1:0]         digit_sel_q, digit_sel_d;

  // Per-frame snapshot of the producer inputs.
  logic [4*NUM_DIGITS-1:0]   snap_bcd_q, snap_bcd_d;
  logic [NUM_DIGITS-1:0]     snap_dp_q, snap_dp_d;
  logic                      snap_blz_q, snap_blz_d;

  // Registered pin drivers.
  logic [NUM_DIGITS-1:0]     an_q, an_d;
  logic [6:0]                seg_q, seg_d;
  logic                      dp_q, dp_d;
  logic                      frame_tick_q, frame_tick_d;

  // Decode helpers.
  logic                      slot_end;
  logic                      frame_end;
  logic [3:0]                snap_nib [NUM_DIGITS];
  logic [3:0]                cur_nib;
  logic [6:0]                dec_seg;
  logic [NUM_DIGITS-1:0]     lz_blank;
  logic                      all_zero;
  logic                      pwm_on;

  // Split the snapshot into one nibble per digit so it can be indexed by digit_sel.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
    assign snap_nib[gi] = snap_bcd_q[4*gi +: 4];
  end

  assign slot_end  = (prescaler_q == PRE_W'(REFRESH_DIV - 1));
  assign frame_end = slot_end && (digit_sel_q == DSEL_W'(NUM_DIGITS - 1));
  assign cur_nib   = snap_nib[digit_sel_q];

  // Scan counters: prescaler wraps each slot; digit_sel steps once per slot and wraps per frame.
  always_comb begin
    prescaler_d = prescaler_q + PRE_W'(1);
    digit_sel_d = digit_sel_q;
    if (slot_end) begin
      prescaler_d = '0;
      if (frame_end) begin
        digit_sel_d = '0;
      end else begin
        digit_sel_d = digit_sel_q + DSEL_W'(1);
      end
    end
  end

  // Snapshot the inputs only on the frame wrap edge, and flag that edge for one cycle.
  always_comb begin
    snap_bcd_d   = snap_bcd_q;
    snap_dp_d    = snap_dp_q;
    snap_blz_d   = snap_blz_q;
    frame_tick_d = frame_end;
    if (frame_end) begin
      snap_bcd_d = bus.bcd;
      snap_dp_d  = bus.dp_in;
      snap_blz_d = bus.blank_lz;
    end
  end

  // Leading-zero mask: walk down from the top digit while every nibble seen so far is zero.
  always_comb begin
    lz_blank = '0;
    all_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      all_zero    = all_zero & (snap_nib[i] == 4'd0);
      lz_blank[i] = snap_blz_q & all_zero;
    end
  end

  // Nibble to segment pattern {g,f,e,d,c,b,a}, active-low.
  always_comb begin
    dec_seg = 7'h7F;
    case (cur_nib)
      4'd0:  dec_seg = 7'h40;
      4'd1:  dec_seg = 7'h79;
      4'd2:  dec_seg = 7'h24;
      4'd3:  dec_seg = 7'h30;
      4'd4:  dec_seg = 7'h19;
      4'd5:  dec_seg = 7'h12;
      4'd6:  dec_seg = 7'h02;
      4'd7:  dec_seg = 7'h78;
      4'd8:  dec_seg = 7'h00;
      4'd9:  dec_seg = 7'h10;
`ifdef HEX_DECODE_EN
      4'd10: dec_seg = 7'h08;
      4'd11: dec_seg = 7'h03;
      4'd12: dec_seg = 7'h46;
      4'd13: dec_seg = 7'h21;
      4'd14: dec_seg = 7'h06;
      4'd15: dec_seg = 7'h0E;
`endif
      default: dec_seg = 7'h7F;
    endcase
  end

  // PWM duty comes from the low prescaler bits, so each slot holds whole PWM periods.
  assign pwm_on = (prescaler_q[BRIGHT_BITS-1:0] <= bus.brightness);

  // Next pin state: dark unless the PWM window is open and the current digit is not blanked.
  always_comb begin
    an_d  = '1;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (pwm_on && !lz_blank[digit_sel_q]) begin
      an_d[digit_sel_q] = 1'b0;
      seg_d             = dec_seg;
      dp_d              = ~snap_dp_q[digit_sel_q];
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prescaler_q  <= '0;
      digit_sel_q  <= '0;
      snap_bcd_q   <= '0;
      snap_dp_q    <= '0;
      snap_blz_q   <= 1'b0;
      an_q         <= '1;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      prescaler_q  <= prescaler_d;
      digit_sel_q  <= digit_sel_d;
      snap_bcd_q   <= snap_bcd_d;
      snap_dp_q    <= snap_dp_d;
      snap_blz_q   <= snap_blz_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_multiseg_display_n.sv
// Bench for multiseg_display_n with NUM_DIGITS=4, REFRESH_DIV=16, BRIGHT_BITS=4.
// A frame-level model predicts the outputs from the count of edges since reset.
// Directed frame statistics with hand-computed values pin that model.
module tb_multiseg_display_n;
  localparam int ND    = 4;
  localparam int RD    = 16;
  localparam int BB    = 4;
  localparam int FRAME = ND * RD;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  multiseg_display_n_if #(.NUM_DIGITS(ND), .BRIGHT_BITS(BB)) bus_if ();

  multiseg_display_n #(
    .NUM_DIGITS(ND),
    .REFRESH_DIV(RD),
    .BRIGHT_BITS(BB)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int tcyc = 0;

  // Model state: edges since reset release and the frame snapshot.
  int          m;
  logic [15:0] m_bcd;
  logic [3:0]  m_dp;
  logic        m_blz;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic        e_ft;
  logic [6:0]  seg_tab [16];

  // Frame statistics gathered from the DUT.
  int          cnt_dig [ND];
  logic [6:0]  seg_seen [ND];
  int          cnt_dark;
  int          cnt_dp0;
  int          cnt_dp_d2;
  int          ft_pos;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, tcyc, act, exp);
    end
  endtask

  // Predict the outputs registered at this edge.
  // The prediction uses the scan position and snapshot held before the edge.
  task automatic model_edge();
    int p;
    int d;
    logic blank;
    logic [3:0] onehot;
    if (!reset_n) begin
      m = 0; m_bcd = '0; m_dp = '0; m_blz = 1'b0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_ft = 1'b0;
    end else begin
      p = m % RD;
      d = (m / RD) % ND;
      blank = 1'b0;
      if (m_blz && d >= 1) begin
        blank = 1'b1;
        for (int k = d; k < ND; k++)
          if (m_bcd[4*k +: 4] != 4'd0) blank = 1'b0;
      end
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      if ((p % (1 << BB)) <= int'(bus_if.brightness) && !blank) begin
        onehot = 4'b0001 << d;
        e_an   = ~onehot;
        e_seg  = seg_tab[m_bcd[4*d +: 4]];
        e_dp   = ~m_dp[d];
      end
      e_ft = ((m % FRAME) == FRAME - 1);
      if (e_ft) begin
        m_bcd = bus_if.bcd;
        m_dp  = bus_if.dp_in;
        m_blz = bus_if.blank_lz;
      end
      m++;
    end
  endtask

  // One clock: update the model at the edge, then compare on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    tcyc++;
    check("an", 32'(bus_if.an), 32'(e_an));
    check("seg", 32'(bus_if.seg), 32'(e_seg));
    check("dp", 32'(bus_if.dp), 32'(e_dp));
    check("frame_tick", 32'(bus_if.frame_tick), 32'(e_ft));
  endtask

  task automatic wait_ft();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (bus_if.frame_tick !== 1'b1 && n < 3 * FRAME);
    check("ft_seen", 32'(bus_if.frame_tick), 32'd1);
  endtask

  task automatic measure_frame();
    logic [3:0] pat;
    for (int i = 0; i < ND; i++) begin cnt_dig[i] = 0; seg_seen[i] = 7'h7F; end
    cnt_dark = 0; cnt_dp0 = 0; cnt_dp_d2 = 0; ft_pos = -1;
    for (int s = 1; s <= FRAME; s++) begin
      step();
      if (bus_if.an == 4'hF) cnt_dark++;
      for (int i = 0; i < ND; i++) begin
        pat = 4'b0001 << i;
        if (bus_if.an == ~pat) begin cnt_dig[i]++; seg_seen[i] = bus_if.seg; end
      end
      if (bus_if.dp == 1'b0) begin
        cnt_dp0++;
        if (bus_if.an == 4'b1011) cnt_dp_d2++;
      end
      if (bus_if.frame_tick && ft_pos < 0) ft_pos = s;
    end
  endtask

  initial begin
    seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
    seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;
    seg_tab[8] = 7'h00; seg_tab[9] = 7'h10;
`ifdef HEX_DECODE_EN
    seg_tab[10] = 7'h08; seg_tab[11] = 7'h03; seg_tab[12] = 7'h46;
    seg_tab[13] = 7'h21; seg_tab[14] = 7'h06; seg_tab[15] = 7'h0E;
`else
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'h7F;
`endif

    bus_if.bcd = '0; bus_if.dp_in = '0; bus_if.blank_lz = 1'b0; bus_if.brightness = 4'hF;
    reset_n = 1'b0;
    step();
    step();
    check("rst_an", 32'(bus_if.an), 32'hF);
    check("rst_seg", 32'(bus_if.seg), 32'h7F);
    check("rst_dp", 32'(bus_if.dp), 32'h1);
    check("rst_ft", 32'(bus_if.frame_tick), 32'h0);

    // Basic scan of 1234 at full brightness; the first frame shows the zero snapshot.
    bus_if.bcd = 16'h1234;
    reset_n = 1'b1;
    step();
    check("first_an", 32'(bus_if.an), 32'hE);
    check("first_seg", 32'(bus_if.seg), 32'h40);
    wait_ft();
    measure_frame();
    for (int i = 0; i < ND; i++) check("scan_cnt", 32'(cnt_dig[i]), 32'd16);
    check("scan_seg0", 32'(seg_seen[0]), 32'h19);
    check("scan_seg1", 32'(seg_seen[1]), 32'h30);
    check("scan_seg2", 32'(seg_seen[2]), 32'h24);
    check("scan_seg3", 32'(seg_seen[3]), 32'h79);
    check("scan_ftpos", 32'(ft_pos), 32'd64);

    // Brightness 0: one lit cycle per slot. Brightness 7: eight lit cycles per slot.
    bus_if.brightness = 4'h0;
    measure_frame();
    check("bright0_lit", 32'(FRAME - cnt_dark), 32'd4);
    bus_if.brightness = 4'h7;
    measure_frame();
    check("bright7_lit", 32'(FRAME - cnt_dark), 32'd32);
    bus_if.brightness = 4'hF;

    // Leading-zero blanking.
    bus_if.bcd = 16'h0050; bus_if.blank_lz = 1'b1;
    wait_ft();
    measure_frame();
    check("lz_d3", 32'(cnt_dig[3]), 32'd0);
    check("lz_d2", 32'(cnt_dig[2]), 32'd0);
    check("lz_d1", 32'(cnt_dig[1]), 32'd16);
    check("lz_seg1", 32'(seg_seen[1]), 32'h12);
    check("lz_seg0", 32'(seg_seen[0]), 32'h40);
    bus_if.bcd = 16'h0000;
    wait_ft();
    measure_frame();
    check("lz0_d0", 32'(cnt_dig[0]), 32'd16);
    check("lz0_dark", 32'(cnt_dark), 32'd48);
    check("lz0_seg0", 32'(seg_seen[0]), 32'h40);

    // A mid-frame change must not tear the frame currently on display.
    bus_if.bcd = 16'h1111; bus_if.blank_lz = 1'b0;
    wait_ft();
    for (int s = 0; s < 20; s++) step();
    bus_if.bcd = 16'h2222;
    check("tear_an", 32'(bus_if.an), 32'hD);
    check("tear_seg_old", 32'(bus_if.seg), 32'h79);
    for (int s = 0; s < 30; s++) step();
    check("tear_seg_old3", 32'(bus_if.seg), 32'h79);
    for (int s = 0; s < 14; s++) step();
    check("tear_ft", 32'(bus_if.frame_tick), 32'd1);
    measure_frame();
    check("tear_new0", 32'(seg_seen[0]), 32'h24);
    check("tear_new3", 32'(seg_seen[3]), 32'h24);

    // Decimal points, then a blanked digit suppressing its point.
    bus_if.dp_in = 4'b0100;
    wait_ft();
    measure_frame();
    check("dp_total", 32'(cnt_dp0), 32'd16);
    check("dp_on_d2", 32'(cnt_dp_d2), 32'd16);
    bus_if.blank_lz = 1'b1; bus_if.bcd = 16'h0000;
    wait_ft();
    measure_frame();
    check("dp_blank", 32'(cnt_dp0), 32'd0);

    // Reset mid-slot of digit 2; the scan restarts on a zero snapshot.
    bus_if.bcd = 16'h1234; bus_if.dp_in = 4'b0000; bus_if.blank_lz = 1'b0;
    wait_ft();
    measure_frame();
    for (int s = 0; s < 37; s++) step();
    reset_n = 1'b0;
    step();
    check("mrst_an", 32'(bus_if.an), 32'hF);
    check("mrst_seg", 32'(bus_if.seg), 32'h7F);
    check("mrst_dp", 32'(bus_if.dp), 32'h1);
    reset_n = 1'b1;
    measure_frame();
    check("mrst_ftpos", 32'(ft_pos), 32'd64);
    check("mrst_d0", 32'(cnt_dig[0]), 32'd16);
    for (int i = 0; i < ND; i++) check("mrst_seg", 32'(seg_seen[i]), 32'h40);

    // Hex nibble A on digit 0.
    bus_if.bcd = 16'h000A;
    wait_ft();
    measure_frame();
    check("hex_d0", 32'(cnt_dig[0]), 32'd16);
`ifdef HEX_DECODE_EN
    check("hex_seg", 32'(seg_seen[0]), 32'h08);
`else
    check("hex_seg", 32'(seg_seen[0]), 32'h7F);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
